ser_rx_40: RTL and testbench
============================

// Module: ser_rx_40
// PURPOSE
//   Downstream receiver for the 40 MHz serial link. Takes the 1-bit LSB-first stream
//   from the parallel-to-serial stage and aligns to frames using a sync byte.
//   Frame = 1 sync byte + (FRAME_LEN-1) payload bytes.
//   Reassembles payload bytes and presents them as 8-bit words with a valid strobe.
//   Tracks link lock and reports sync errors.
// PARAMETERS
//   SYNC_WORD   8'hBC  frame alignment byte, LSB transmitted first
//   FRAME_LEN   16     bytes per frame including sync byte; legal range 2..256
//   MISS_LIMIT  3      consecutive bad sync bytes while LOCKED before returning to HUNT; legal range 1..15
// PORTS
//   clock_40    in   1  40 MHz clock; all logic on rising edge
//   reset       in   1  synchronous, active-high
//   bit_in      in   1  serial data bit, LSB of each byte first
//   bit_valid   in   1  bit_in is sampled only when high
//   data_out    out  8  reassembled payload byte
//   data_valid  out  1  1-cycle strobe; data_out is valid
//   sof         out  1  1-cycle strobe with data_valid on the first payload byte of a frame
//   locked      out  1  high while the FSM is in LOCKED
//   sync_err    out  1  1-cycle strobe: the frame-boundary byte was not SYNC_WORD while LOCKED
// BEHAVIOUR
//   Reset (reset=1 at a clock edge, including mid-byte or mid-frame):
//     state=HUNT; shift reg=0; bit_cnt=0; byte_cnt=0; miss_cnt=0.
//     All outputs 0.
//   Shift register: on each bit_valid, sr <= {bit_in, sr[7:1]}. After 8 bits, sr[0] is the first bit received.
//   bit_valid=0: state, counters and sr hold. Strobes are low.
//   FSM, advancing only on bit_valid cycles:
//     HUNT   - Compare the updated sr to SYNC_WORD on every bit (sliding window).
//              On match: go to VERIFY, bit_cnt=0, byte_cnt=1.
//     VERIFY - Count 8 bits per byte. No data output.
//              At the byte where byte_cnt==FRAME_LEN:
//                sync -> LOCKED, byte_cnt=1, miss_cnt=0
//                else -> HUNT
//     LOCKED - Each completed byte with byte_cnt in 1..FRAME_LEN-1 is payload:
//                data_out=byte, data_valid=1.
//                sof=1 when byte_cnt==1.
//              Boundary byte (byte_cnt==FRAME_LEN) is never output:
//                if it is sync -> miss_cnt=0
//                else -> sync_err=1, miss_cnt+1
//              When miss_cnt reaches MISS_LIMIT, go to HUNT in the same cycle; locked drops the next cycle.
//              byte_cnt wraps FRAME_LEN -> 1 regardless of the sync result (flywheel).
//   Latency: data_out and data_valid are registered. They assert on the clock edge after the 8th bit of the byte is sampled.
//   bit_cnt wraps 7->0. byte_cnt is ceil(log2(FRAME_LEN+1)) bits wide.
//   Between strobes, data_out holds its last value.
//   locked = (state==LOCKED), registered.
//   An idle gap (bit_valid low) mid-byte does not disturb alignment.
// STRUCTURE
//   Header ser_link_defs.vh holds:
//     SYNC_WORD default
//     state encodings: HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2
//   These are shared with the transmit side.
//   Sub-module rx_shift8: 8-bit LSB-first shift register with enable and a sync-match compare output.
//   FSM and counters live in ser_rx_40.
// TESTING
//   1. Reset, then send 0xBC followed by 15 payload bytes 0x01..0x0F, then 0xBC
//      -> no data_valid in VERIFY; locked=1 after the 2nd sync.
//   2. Locked link, next frame with payload 0x10..0x1E
//      -> 15 data_valid strobes with matching bytes; sof only with 0x10; sync byte never output.
//   3. Prepend 3 random bits before the first sync; insert bit_valid=0 gaps of 1..5 cycles mid-byte
//      -> alignment and data identical to test 2.
//   4. While locked, corrupt the sync bytes (0xBD) of 2 frames, then send a good one
//      -> sync_err pulses twice; locked stays 1; miss_cnt clears; payload is still output.
//   5. Corrupt 3 consecutive sync bytes
//      -> 3 sync_err pulses; locked=0 after the 3rd; no data_valid until re-lock.
//   6. Assert reset mid-byte while locked
//      -> all outputs 0 the next cycle; re-lock requires the full HUNT->VERIFY->LOCKED sequence.

Source files
------------

// File: rtl/ser_rx_40_pkg.sv
// ser_rx_40_pkg
//   Shared definitions for the 40 MHz serial link (receive and transmit sides).
//   Provides the default frame alignment byte and the receiver FSM state
//   encodings, which the transmit side relies on matching.
package ser_rx_40_pkg;

  // Frame alignment byte; bit 0 is the first bit on the wire.
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } link_state_t;

endpackage

// File: rtl/ser_rx_40_shift8.sv
// rx_shift8
//   8-bit LSB-first deserialising shift register with enable, plus a
//   comparator against the frame alignment byte.
//   o_byte / o_match describe the register contents *after* the current bit
//   is shifted in, so the FSM can act on a completed byte in the same cycle
//   the last bit is sampled.
// Ports
//   clock_40  in   1  clock, rising edge
//   reset     in   1  synchronous, active-high; clears the register
//   i_en      in   1  shift enable (bit strobe)
//   i_bit     in   1  serial bit
//   o_byte    out  8  register value including the current bit
//   o_match   out  1  o_byte equals MATCH_WORD
module rx_shift8 #(
  parameter logic [7:0] MATCH_WORD = 8'hBC
) (
  input  logic       clock_40,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_byte,
  output logic       o_match
);

  logic [7:0] r_sr;
  logic [7:0] w_sr_next;

  // New bit enters at the top; the oldest bit ends up in bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shift
      assign w_sr_next[gi] = r_sr[gi+1];
    end
  endgenerate
  assign w_sr_next[7] = i_bit;

  always_ff @(posedge clock_40) begin
    if (reset) begin
      r_sr <= 8'h00;
    end else if (i_en) begin
      r_sr <= w_sr_next;
    end
  end

  assign o_byte  = w_sr_next;
  assign o_match = (w_sr_next == MATCH_WORD);

endmodule

// File: rtl/ser_rx_40.sv
// ser_rx_40
//   Receiver for the 40 MHz serial link. Hunts for the sync byte on a sliding
//   window, verifies it one frame later, then flywheels on the frame length,
//   emitting payload bytes and flagging bad frame-boundary bytes. Loses lock
//   after MISS_LIMIT consecutive bad boundary bytes.
// Ports
//   clock_40    in   1  40 MHz clock, rising edge
//   reset       in   1  synchronous, active-high
//   bit_in      in   1  serial data, LSB of each byte first
//   bit_valid   in   1  bit_in qualifier
//   data_out    out  8  payload byte (holds between strobes)
//   data_valid  out  1  1-cycle strobe for data_out
//   sof         out  1  strobe with data_valid on first payload byte of a frame
//   locked      out  1  receiver is in LOCKED
//   sync_err    out  1  1-cycle strobe: bad boundary byte while locked
module ser_rx_40
  import ser_rx_40_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
  parameter int         FRAME_LEN  = 16,
  parameter int         MISS_LIMIT = 3
) (
  input  logic       clock_40,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sof,
  output logic       locked,
  output logic       sync_err
);

  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_LEN);
  localparam logic [BCW-1:0] FIRST_BYTE = BCW'(1);
  localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

  link_state_t    r_state, w_state_next;
  logic [2:0]     r_bit_cnt, w_bit_cnt_next;
  logic [BCW-1:0] r_byte_cnt, w_byte_cnt_next;
  logic [3:0]     r_miss_cnt, w_miss_cnt_next;
  logic [7:0]     r_data, w_data_next;
  logic           r_data_valid, w_data_valid_next;
  logic           r_sof, w_sof_next;
  logic           r_sync_err, w_sync_err_next;
  logic           r_locked;

  logic [7:0]     w_byte;
  logic           w_match;
  logic           w_byte_done;
  logic [3:0]     w_miss_inc;

  rx_shift8 #(
    .MATCH_WORD(SYNC_WORD)
  ) u_shift (
    .clock_40(clock_40),
    .reset   (reset),
    .i_en    (bit_valid),
    .i_bit   (bit_in),
    .o_byte  (w_byte),
    .o_match (w_match)
  );

  // The current bit completes a byte (only meaningful when bit_valid is high).
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  always_ff @(posedge clock_40) begin
    if (reset) begin
      r_state      <= HUNT;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= '0;
      r_miss_cnt   <= 4'd0;
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_miss_cnt   <= w_miss_cnt_next;
      r_data       <= w_data_next;
      r_data_valid <= w_data_valid_next;
      r_sof        <= w_sof_next;
      r_sync_err   <= w_sync_err_next;
      r_locked     <= (w_state_next == LOCKED);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt;
    w_byte_cnt_next   = r_byte_cnt;
    w_miss_cnt_next   = r_miss_cnt;
    w_data_next       = r_data;
    w_data_valid_next = 1'b0;
    w_sof_next        = 1'b0;
    w_sync_err_next   = 1'b0;

    if (bit_valid) begin
      case (r_state)
        HUNT: begin
          // Sliding-window search: any bit position may start alignment.
          if (w_match) begin
            w_state_next    = VERIFY;
            w_bit_cnt_next  = 3'd0;
            w_byte_cnt_next = FIRST_BYTE;
          end
        end

        VERIFY: begin
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_byte_cnt == LAST_BYTE) begin
              if (w_match) begin
                w_state_next    = LOCKED;
                w_byte_cnt_next = FIRST_BYTE;
                w_miss_cnt_next = 4'd0;
              end else begin
                w_state_next    = HUNT;
                w_bit_cnt_next  = 3'd0;
                w_byte_cnt_next = '0;
              end
            end else begin
              w_byte_cnt_next = r_byte_cnt + FIRST_BYTE;
            end
          end
        end

        LOCKED: begin
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_byte_cnt != LAST_BYTE) begin
              w_data_next       = w_byte;
              w_data_valid_next = 1'b1;
              w_sof_next        = (r_byte_cnt == FIRST_BYTE);
              w_byte_cnt_next   = r_byte_cnt + FIRST_BYTE;
            end else begin
              // Flywheel: the frame position advances even on a bad boundary.
              w_byte_cnt_next = FIRST_BYTE;
              if (w_match) begin
                w_miss_cnt_next = 4'd0;
              end else begin
                w_sync_err_next = 1'b1;
                w_miss_cnt_next = w_miss_inc;
                if (w_miss_inc >= MISS_MAX) begin
                  w_state_next    = HUNT;
                  w_bit_cnt_next  = 3'd0;
                  w_byte_cnt_next = '0;
                  w_miss_cnt_next = 4'd0;
                end
              end
            end
          end
        end

        default: begin
          w_state_next = HUNT;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_data_valid;
  assign sof        = r_sof;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_ser_rx_40.sv
module tb_ser_rx_40;

  logic       clock_40  = 1'b0;
  logic       reset     = 1'b1;
  logic       bit_in    = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sof;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  bit gaps_en  = 1'b0;

  // Scoreboard entries: {expected sof, expected byte}
  logic [8:0] exp_q[$];

  ser_rx_40 dut (
    .clock_40  (clock_40),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .data_valid(data_valid),
    .sof       (sof),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #12 clock_40 = ~clock_40;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clock_40);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clock_40);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (gaps_en && i > 0 && $urandom_range(0, 2) == 0)
        idle(int'($urandom_range(1, 5)));
      send_bit(b[i]);
    end
  endtask

  // 15 payload bytes first, first+step, ...; pushed to the scoreboard when expected out.
  task automatic send_payload(input logic [7:0] first, input logic [7:0] step, input bit exp_out);
    logic [7:0] b;
    for (int k = 0; k < 15; k++) begin
      b = first + step * 8'(k);
      if (exp_out) exp_q.push_back({(k == 0), b});
      send_byte(b);
    end
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    bit_valid = 1'b0;
    @(posedge clock_40);
    #1;
    reset = 1'b0;
  endtask

  // Output monitor: one line per received payload byte.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clock_40);
      if (sync_err) err_cnt++;
      if (sof && !data_valid) chk("sof_without_dv", 32'(sof), 32'd0);
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dv", 32'(data_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("rx byte 0x%02h sof=%0d (exp 0x%02h sof=%0d)", data_out, sof, e[7:0], e[8]);
          chk("data", 32'(data_out), 32'(e[7:0]));
          chk("sof", 32'(sof), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset
    repeat (3) @(posedge clock_40);
    #1;
    reset = 1'b0;
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_sof", 32'(sof), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(sync_err), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);

    // 1: acquire lock, nothing output while verifying
    send_byte(8'hBC);
    send_payload(8'h01, 8'h01, 1'b0);
    idle(2);
    chk("t1_verify_unlocked", 32'(locked), 32'd0);
    send_byte(8'hBC);
    idle(2);
    chk("t1_locked", 32'(locked), 32'd1);

    // 2: one locked frame
    send_payload(8'h10, 8'h01, 1'b1);
    send_byte(8'hBC);
    idle(2);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_data_hold", 32'(data_out), 32'h1E);

    // 3: random leading bits, idle gaps mid-byte
    pulse_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    gaps_en = 1'b1;
    send_byte(8'hBC);
    send_payload(8'h01, 8'h01, 1'b0);
    send_byte(8'hBC);
    send_payload(8'h10, 8'h01, 1'b1);
    send_byte(8'hBC);
    gaps_en = 1'b0;
    idle(2);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    chk("t3_locked", 32'(locked), 32'd1);

    // 4: two bad boundaries then a good one
    base = err_cnt;
    send_payload(8'h20, 8'h01, 1'b1);
    send_byte(8'hBD);
    send_payload(8'h30, 8'h01, 1'b1);
    send_byte(8'hBD);
    send_payload(8'h40, 8'h01, 1'b1);
    send_byte(8'hBC);
    idle(2);
    chk("t4_sync_errs", 32'(err_cnt - base), 32'd2);
    chk("t4_locked", 32'(locked), 32'd1);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: three bad boundaries lose lock (miss count was cleared by test 4)
    base = err_cnt;
    send_payload(8'h50, 8'h01, 1'b1);
    send_byte(8'hBD);
    idle(2);
    chk("t5_locked_after_1", 32'(locked), 32'd1);
    send_payload(8'h60, 8'h01, 1'b1);
    send_byte(8'hBD);
    idle(2);
    chk("t5_locked_after_2", 32'(locked), 32'd1);
    send_payload(8'h70, 8'h01, 1'b1);
    send_byte(8'hBD);
    idle(2);
    chk("t5_unlocked_after_3", 32'(locked), 32'd0);
    chk("t5_sync_errs", 32'(err_cnt - base), 32'd3);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hBC);
    send_payload(8'h00, 8'h00, 1'b0);
    send_byte(8'hBC);
    idle(2);
    chk("t5_relocked", 32'(locked), 32'd1);
    send_payload(8'h80, 8'h01, 1'b1);
    send_byte(8'hBC);
    idle(2);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // 6: reset mid-byte while locked
    send_payload(8'h90, 8'h01, 1'b1);
    send_byte(8'hBC);
    idle(2);
    chk("t6_drain_before", 32'(exp_q.size()), 32'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_reset();
    chk("t6_rst_dv", 32'(data_valid), 32'd0);
    chk("t6_rst_sof", 32'(sof), 32'd0);
    chk("t6_rst_locked", 32'(locked), 32'd0);
    chk("t6_rst_err", 32'(sync_err), 32'd0);
    chk("t6_rst_data", 32'(data_out), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'h00);
    idle(2);
    chk("t6_hunt_unlocked", 32'(locked), 32'd0);
    send_byte(8'hBC);
    send_payload(8'hA0, 8'h01, 1'b0);
    idle(2);
    chk("t6_verify_unlocked", 32'(locked), 32'd0);
    send_byte(8'hBC);
    idle(2);
    chk("t6_relocked", 32'(locked), 32'd1);
    send_payload(8'hB0, 8'h01, 1'b1);
    send_byte(8'hBC);
    idle(3);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
